// File: rtl/abl_seq_if.sv
// Bundle between the microcode decoder / ABL datapath and the addressing-mode sequencer.
// master drives the decoder-side inputs and observes the strobes; slave is the sequencer.
interface abl_seq_if;
   logic       rdy;
   logic       start;
   logic [1:0] mode;
   logic       idx_en;
   logic       idx_sel;
   logic       take;
   logic       db7;
   logic       CO;
   logic [4:0] abl_op;
   logic       abl_ci;
   logic [1:0] reg_sel;
   logic       ld_ahl;
   logic       ld_pc;
   logic       inc_pc;
   logic [1:0] abh_fix;
   logic       busy;
   logic       done;
   logic [3:0] dbg_state;

   // Handshake: a sequence is accepted when start=1 and rdy=1 while busy=0;
   // rdy=0 freezes the sequencer and forces all strobes to their idle values.
   modport master (
      output rdy, start, mode, idx_en, idx_sel, take, db7, CO,
      input  abl_op, abl_ci, reg_sel, ld_ahl, ld_pc, inc_pc, abh_fix, busy, done, dbg_state
   );

   modport slave (
      input  rdy, start, mode, idx_en, idx_sel, take, db7, CO,
      output abl_op, abl_ci, reg_sel, ld_ahl, ld_pc, inc_pc, abh_fix, busy, done, dbg_state
   );
endinterface

// File: rtl/abl_seq.sv
// Addressing-mode sequencer for the address-bus-low unit: walks ZP/ABS/BRANCH/IMM
// sequences, inserting a page-fix cycle when the ABL adder crosses a page boundary.
module abl_seq (
   input  logic     clk,
   input  logic     RST,
   abl_seq_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_OPND1, S_OPND2, S_ZPA, S_ABSA, S_BRT, S_BRN, S_FIX, S_RESTORE, S_INEXT
   } state_e;

   localparam logic [1:0] M_ZP  = 2'b00;
   localparam logic [1:0] M_ABS = 2'b01;
   localparam logic [1:0] M_IMM = 2'b11;

   localparam logic [4:0] OP_HOLD    = 5'b01000;
   localparam logic [4:0] OP_ZPA     = 5'b00110;
   localparam logic [4:0] OP_ABSA    = 5'b00111;
   localparam logic [4:0] OP_BR      = 5'b01010;
   localparam logic [4:0] OP_RESTORE = 5'b00000;

   state_e     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic       idx_en_q, idx_en_d;
   logic       idx_sel_q, idx_sel_d;
   logic       take_q, take_d;
   logic [1:0] fix_q, fix_d;

   logic [4:0] op;
   logic       ci, ahl, ldpc, incpc, dn;
   logic [1:0] rsel, fix;
   logic [1:0] idx_rsel;

   assign idx_rsel = idx_en_q ? {1'b0, idx_sel_q} : 2'b11;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      idx_en_d  = idx_en_q;
      idx_sel_d = idx_sel_q;
      take_d    = take_q;
      fix_d     = fix_q;
      if (bus.rdy) begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d   = S_OPND1;
                  mode_d    = bus.mode;
                  idx_en_d  = bus.idx_en;
                  idx_sel_d = bus.idx_sel;
                  take_d    = bus.take;
                  fix_d     = 2'b00;
               end
            end
            S_OPND1: begin
               case (mode_q)
                  M_ZP:    state_d = S_ZPA;
                  M_ABS:   state_d = S_OPND2;
                  M_IMM:   state_d = S_INEXT;
                  default: state_d = take_q ? S_BRT : S_BRN;
               endcase
            end
            S_OPND2: state_d = S_ABSA;
            S_ZPA:   state_d = S_RESTORE;
            S_ABSA: begin
               if (bus.CO) begin
                  state_d = S_FIX;
                  fix_d   = 2'b01;
               end else begin
                  state_d = S_RESTORE;
               end
            end
            // A branch crosses a page when the carry disagrees with the offset sign.
            S_BRT: begin
               if (bus.CO != bus.db7) begin
                  state_d = S_FIX;
                  fix_d   = bus.CO ? 2'b01 : 2'b10;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FIX:   state_d = (mode_q == M_ABS) ? S_RESTORE : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= S_IDLE;
         mode_q    <= 2'b00;
         idx_en_q  <= 1'b0;
         idx_sel_q <= 1'b0;
         take_q    <= 1'b0;
         fix_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         idx_en_q  <= idx_en_d;
         idx_sel_q <= idx_sel_d;
         take_q    <= take_d;
         fix_q     <= fix_d;
      end
   end

   // Strobes are gated by rdy so a stalled cycle never loads or completes anything.
   always_comb begin
      op    = OP_HOLD;
      ci    = 1'b0;
      rsel  = 2'b11;
      ahl   = 1'b0;
      ldpc  = 1'b0;
      incpc = 1'b0;
      fix   = 2'b00;
      dn    = 1'b0;
      if (bus.rdy) begin
         case (state_q)
            S_OPND1: begin
               ci = 1'b1; ldpc = 1'b1; incpc = 1'b1;
            end
            S_OPND2: begin
               ci = 1'b1; ahl = 1'b1; ldpc = 1'b1; incpc = 1'b1;
            end
            S_ZPA: begin
               op = OP_ZPA; rsel = idx_rsel;
            end
            S_ABSA: begin
               op = OP_ABSA; rsel = idx_rsel;
            end
            S_BRT: begin
               op = OP_BR; ci = 1'b1; dn = (bus.CO == bus.db7);
            end
            S_BRN: begin
               ci = 1'b1; dn = 1'b1;
            end
            S_FIX: begin
               fix = fix_q; dn = (mode_q != M_ABS);
            end
            S_RESTORE: begin
               op = OP_RESTORE; ci = 1'b1; dn = 1'b1;
            end
            S_INEXT: begin
               ci = 1'b1; ldpc = 1'b1; incpc = 1'b1; dn = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.abl_op    = op;
   assign bus.abl_ci    = ci;
   assign bus.reg_sel   = rsel;
   assign bus.ld_ahl    = ahl;
   assign bus.ld_pc     = ldpc;
   assign bus.inc_pc    = incpc;
   assign bus.abh_fix   = fix;
   assign bus.done      = dn;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_abl_seq.sv
// Bench for abl_seq: a transaction-level model expands each sequence into its expected
// per-cycle output vectors; a negedge monitor pops and compares them on every advancing cycle.
module tb_abl_seq;

   localparam int W = 14;
   typedef logic [W-1:0] vec_t;

   logic clk = 1'b0;
   logic RST;
   abl_seq_if bus();

   abl_seq dut (.clk(clk), .RST(RST), .bus(bus));

   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   vec_t got;
   vec_t e;
   vec_t def_v;

   function automatic vec_t mk(logic [4:0] op, logic ci, logic [1:0] rs, logic ahl,
                               logic pc, logic inc, logic [1:0] fix, logic dn);
      return {op, ci, rs, ahl, pc, inc, fix, dn};
   endfunction

   assign got = {bus.abl_op, bus.abl_ci, bus.reg_sel, bus.ld_ahl, bus.ld_pc,
                 bus.inc_pc, bus.abh_fix, bus.done};

   // Expected cycle list for one sequence, from mode, flags and the boundary outcome.
   task automatic model(input logic [1:0] m, input logic ie, input logic is,
                        input logic tk, input logic co, input logic d7);
      logic [1:0] rs;
      vec_t       restore_v;
      rs        = ie ? {1'b0, is} : 2'b11;
      restore_v = mk(5'b00000, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      exp_q.push_back(mk(5'b01000, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0));
      case (m)
         2'b11: exp_q.push_back(mk(5'b01000, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1));
         2'b00: begin
            exp_q.push_back(mk(5'b00110, 1'b0, rs, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
            exp_q.push_back(restore_v);
         end
         2'b01: begin
            exp_q.push_back(mk(5'b01000, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0));
            exp_q.push_back(mk(5'b00111, 1'b0, rs, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
            if (co) exp_q.push_back(mk(5'b01000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0));
            exp_q.push_back(restore_v);
         end
         default: begin
            if (!tk)
               exp_q.push_back(mk(5'b01000, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
            else if (co == d7)
               exp_q.push_back(mk(5'b01010, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
            else begin
               exp_q.push_back(mk(5'b01010, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
               exp_q.push_back(mk(5'b01000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0,
                                  co ? 2'b01 : 2'b10, 1'b1));
            end
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (mon_en && !RST) begin
         n_tests++;
         if (bus.busy && bus.rdy) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_cycle got=%h required=no active cycle", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_fail++;
                  $display("FAIL cycle_out got=%h required=%h", got, e);
               end
            end
         end else if (got !== def_v) begin
            n_fail++;
            $display("FAIL default_out got=%h required=%h rdy=%b", got, def_v, bus.rdy);
         end
      end
   end

   task automatic check(input string name, input logic [7:0] g, input logic [7:0] x);
      n_tests++;
      if (g !== x) begin
         n_fail++;
         $display("FAIL %s got=%h required=%h", name, g, x);
      end
   endtask

   task automatic run_seq(input logic [1:0] m, input logic ie, input logic is, input logic tk,
                          input logic co, input logic d7, input int stall_first, input bit rnd);
      int n;
      n = 0;
      model(m, ie, is, tk, co, d7);
      bus.start = 1'b1; bus.rdy = 1'b1; bus.mode = m; bus.idx_en = ie;
      bus.idx_sel = is; bus.take = tk; bus.CO = co; bus.db7 = d7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (bus.busy && n < 100) begin
         bus.mode    = 2'($urandom_range(0, 3));
         bus.idx_en  = 1'($urandom_range(0, 1));
         bus.idx_sel = 1'($urandom_range(0, 1));
         bus.take    = 1'($urandom_range(0, 1));
         if (n < stall_first) begin
            bus.rdy   = 1'b0;
            bus.start = (n == 1);
         end else begin
            bus.rdy   = (rnd && n < 30) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.start = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         n++;
      end
      bus.start = 1'b0;
      bus.rdy   = 1'b1;
      check("seq_timeout_busy", {7'd0, bus.busy}, 8'd0);
      check("seq_leftover", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
   endtask

   initial begin
      def_v = mk(5'b01000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      RST = 1'b1;
      bus.rdy = 1'b1; bus.start = 1'b0; bus.mode = 2'b00; bus.idx_en = 1'b0;
      bus.idx_sel = 1'b0; bus.take = 1'b0; bus.CO = 1'b0; bus.db7 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {7'd0, bus.busy}, 8'd0);
      check("rst_op", {3'd0, bus.abl_op}, 8'h08);
      check("rst_done", {7'd0, bus.done}, 8'd0);
      check("rst_reg_sel", {6'd0, bus.reg_sel}, 8'd3);
      RST = 1'b0;
      mon_en = 1'b1;

      run_seq(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_seq(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_seq(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      run_seq(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      run_seq(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      run_seq(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_seq(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_seq(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      run_seq(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);

      // Reset while in the second operand fetch of an ABS sequence.
      mon_en = 1'b0;
      bus.start = 1'b1; bus.mode = 2'b01; bus.CO = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("opnd2_ld_ahl", {7'd0, bus.ld_ahl}, 8'd1);
      RST = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_busy", {7'd0, bus.busy}, 8'd0);
      check("rst_mid_op", {3'd0, bus.abl_op}, 8'h08);
      check("rst_mid_ld_pc", {7'd0, bus.ld_pc}, 8'd0);
      check("rst_mid_done", {7'd0, bus.done}, 8'd0);
      check("rst_mid_fix", {6'd0, bus.abh_fix}, 8'd0);
      RST = 1'b0;

      // Reset while sitting in the fix cycle.
      bus.start = 1'b1; bus.mode = 2'b01; bus.CO = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("fix_dir_abs", {6'd0, bus.abh_fix}, 8'd1);
      RST = 1'b1;
      @(posedge clk); #1;
      check("rst_fix_busy", {7'd0, bus.busy}, 8'd0);
      check("rst_fix_fix", {6'd0, bus.abh_fix}, 8'd0);
      RST = 1'b0;
      mon_en = 1'b1;
      run_seq(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);

      repeat (150) begin
         run_seq(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 0, 1'b1);
         repeat ($urandom_range(0, 2)) begin
            bus.rdy = 1'($urandom_range(0, 1));
            bus.CO  = 1'($urandom_range(0, 1));
            bus.db7 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         bus.rdy = 1'b1;
      end

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
